calc_lexer: RTL

Hardware tokenizer for the calculator interpreter. It converts a byte stream of source text into the token stream the parser consumes, with kinds INT, FLOAT, NAME, + - * / % ** ( ) = NEWLINE and EOF. It sits directly upstream of the parser, with valid/ready on both sides and one token per output handshake.

---
 rtl/calc_lexer.sv | 315 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/calc_lexer.sv
// Byte-stream tokenizer for the calculator parser, valid/ready on both sides.
// Define LEXER_LINE_COL_EN to add tok_line/tok_col position outputs.
module calc_lexer #(
   parameter int unsigned VAL_W    = 32,
   parameter int unsigned NAME_MAX = 8,
   localparam int unsigned LEN_W   = $clog2(NAME_MAX + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [7:0]            in_char,
   input  logic                  in_last,
   output logic                  tok_valid,
   input  logic                  tok_ready,
   output logic [3:0]            tok_kind,
   output logic [VAL_W-1:0]      tok_int,
   output logic [3:0]            tok_frac,
   output logic [8*NAME_MAX-1:0] tok_name,
   output logic [LEN_W-1:0]      tok_name_len,
   output logic                  tok_err,
`ifdef LEXER_LINE_COL_EN
   output logic [15:0]           tok_line,
   output logic [7:0]            tok_col,
`endif
   output logic                  busy
);

   typedef enum logic [2:0] {StIdle, StInt, StFrac, StName, StStar, StFlushEof} state_e;

   localparam logic [3:0] KEof = 4'd0, KInt = 4'd1, KFloat = 4'd2, KName = 4'd3;
   localparam logic [3:0] KPlus = 4'd4, KMinus = 4'd5, KMul = 4'd6, KDiv = 4'd7, KMod = 4'd8;
   localparam logic [3:0] KExp = 4'd9, KLParen = 4'd10, KRParen = 4'd11, KAssign = 4'd12;
   localparam logic [3:0] KNewline = 4'd13, KError = 4'd15;

   state_e                state_q, state_d;
   logic [VAL_W-1:0]      acc_q, acc_d;
   logic [3:0]            frac_q, frac_d;
   logic                  err_q, err_d;
   logic [8*NAME_MAX-1:0] name_q, name_d;
   logic [LEN_W-1:0]      len_q, len_d;
   logic                  open_q, open_d;
   logic [3:0]            open_kind_q, open_kind_d;
   logic                  pend_valid_q, pend_valid_d;
   logic [7:0]            pend_char_q, pend_char_d;
   logic                  pend_last_q, pend_last_d;
   logic                  tok_full_q, tok_full_d;
   logic [3:0]            tok_kind_q, tok_kind_d;
   logic [VAL_W-1:0]      tok_int_q, tok_int_d;
   logic [3:0]            tok_frac_q, tok_frac_d;
   logic [8*NAME_MAX-1:0] tok_name_q, tok_name_d;
   logic [LEN_W-1:0]      tok_len_q, tok_len_d;
   logic                  tok_err_q, tok_err_d;
`ifdef LEXER_LINE_COL_EN
   logic [15:0] line_q, line_d, pend_line_q, pend_line_d, start_line_q, start_line_d;
   logic [15:0] tok_line_q, tok_line_d, cur_line;
   logic [7:0]  col_q, col_d, pend_col_q, pend_col_d, start_col_q, start_col_d;
   logic [7:0]  tok_col_q, tok_col_d, cur_col;
`endif

   logic             tok_free, have, last, is_digit, is_alpha, ovf, ld_simple, ld_open;
   logic [7:0]       c;
   logic [3:0]       ld_kind;
   logic [VAL_W-1:0] ld_val, acc_nx;
   logic [VAL_W+3:0] wide;

   assign in_ready  = !tok_full_q && !pend_valid_q && (state_q != StFlushEof);
   assign tok_free  = !tok_full_q || tok_ready;
   assign tok_valid = tok_full_q;
   assign busy      = (state_q != StIdle) || tok_full_q || pend_valid_q;

   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      frac_d       = frac_q;
      err_d        = err_q;
      name_d       = name_q;
      len_d        = len_q;
      open_d       = open_q;
      open_kind_d  = open_kind_q;
      pend_valid_d = pend_valid_q;
      pend_char_d  = pend_char_q;
      pend_last_d  = pend_last_q;
      tok_full_d   = tok_full_q && !tok_ready;
      tok_kind_d   = tok_kind_q;
      tok_int_d    = tok_int_q;
      tok_frac_d   = tok_frac_q;
      tok_name_d   = tok_name_q;
      tok_len_d    = tok_len_q;
      tok_err_d    = tok_err_q;
      ld_simple    = 1'b0;
      ld_open      = 1'b0;
      ld_kind      = KEof;
      ld_val       = '0;

      // A pending terminator is reprocessed from IDLE before any new byte.
      if (pend_valid_q) begin
         have = tok_free;
         c    = pend_char_q;
         last = pend_last_q;
      end else begin
         have = in_valid && in_ready;
         c    = in_char;
         last = in_last;
      end
      if (have && pend_valid_q) pend_valid_d = 1'b0;

      is_digit = (c >= 8'h30) && (c <= 8'h39);
      is_alpha = ((c >= 8'h61) && (c <= 8'h7A)) || ((c >= 8'h41) && (c <= 8'h5A)) || (c == 8'h5F);
      wide     = {4'd0, acc_q} * (VAL_W + 4)'(10) + (VAL_W + 4)'(c[3:0]);
      ovf      = |wide[VAL_W+3:VAL_W];
      acc_nx   = ovf ? '1 : wide[VAL_W-1:0];

      unique case (state_q)
         StIdle: if (have) begin
            acc_d       = VAL_W'(c[3:0]);
            frac_d      = 4'd0;
            err_d       = 1'b0;
            name_d      = '0;
            name_d[7:0] = c;
            len_d       = LEN_W'(1);
            if (is_digit) begin
               state_d = StInt;  open_kind_d = KInt;
            end else if (is_alpha) begin
               state_d = StName; open_kind_d = KName;
            end else if (c == 8'h2A) begin
               state_d = StStar; open_kind_d = KMul;
            end else if (c != 8'h20 && c != 8'h09 && c != 8'h0D) begin
               ld_simple = 1'b1;
               case (c)
                  8'h2B:   ld_kind = KPlus;
                  8'h2D:   ld_kind = KMinus;
                  8'h2F:   ld_kind = KDiv;
                  8'h25:   ld_kind = KMod;
                  8'h28:   ld_kind = KLParen;
                  8'h29:   ld_kind = KRParen;
                  8'h3D:   ld_kind = KAssign;
                  8'h0A:   ld_kind = KNewline;
                  default: begin ld_kind = KError; ld_val = VAL_W'(c); end
               endcase
            end
            if (last) begin
               state_d = StFlushEof;
               open_d  = is_digit || is_alpha || (c == 8'h2A);
            end
         end
         StInt, StFrac, StName: if (have) begin
            if (state_q == StName ? (is_alpha || is_digit) : is_digit) begin
               if (state_q == StName) begin
                  if (len_q == LEN_W'(NAME_MAX)) err_d = 1'b1;
                  else len_d = len_q + LEN_W'(1);
                  for (int i = 0; i < NAME_MAX; i++) begin
                     if (len_q == LEN_W'(i)) name_d[8*i +: 8] = c;
                  end
               end else if (state_q == StFrac && frac_q == 4'd15) begin
                  err_d = 1'b1;
               end else begin
                  acc_d = acc_nx;
                  err_d = err_q || ovf;
                  if (state_q == StFrac) frac_d = frac_q + 4'd1;
               end
               if (last) begin state_d = StFlushEof; open_d = 1'b1; end
            end else if (state_q == StInt && c == 8'h2E) begin
               state_d     = StFrac;
               open_kind_d = KFloat;
               if (last) begin state_d = StFlushEof; open_d = 1'b1; end
            end else begin
               ld_open      = 1'b1;
               pend_valid_d = 1'b1;
               pend_char_d  = c;
               pend_last_d  = last;
               state_d      = StIdle;
            end
         end
         StStar: if (have) begin
            if (c == 8'h2A) begin
               ld_simple = 1'b1;
               ld_kind   = KExp;
               state_d   = last ? StFlushEof : StIdle;
               open_d    = 1'b0;
            end else begin
               ld_open      = 1'b1;
               pend_valid_d = 1'b1;
               pend_char_d  = c;
               pend_last_d  = last;
               state_d      = StIdle;
            end
         end
         StFlushEof: if (tok_free) begin
            if (open_q) begin
               ld_open = 1'b1;
               open_d  = 1'b0;
            end else begin
               ld_simple = 1'b1;
               ld_kind   = KEof;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (ld_open) begin
         tok_full_d = 1'b1;
         tok_kind_d = open_kind_q;
         tok_int_d  = (open_kind_q == KInt || open_kind_q == KFloat) ? acc_q : '0;
         tok_frac_d = (open_kind_q == KFloat) ? frac_q : 4'd0;
         tok_name_d = (open_kind_q == KName) ? name_q : '0;
         tok_len_d  = (open_kind_q == KName) ? len_q : '0;
         tok_err_d  = err_q;
      end else if (ld_simple) begin
         tok_full_d = 1'b1;
         tok_kind_d = ld_kind;
         tok_int_d  = ld_val;
         tok_frac_d = 4'd0;
         tok_name_d = '0;
         tok_len_d  = '0;
         tok_err_d  = 1'b0;
      end

`ifdef LEXER_LINE_COL_EN
      line_d       = line_q;
      col_d        = col_q;
      start_line_d = start_line_q;
      start_col_d  = start_col_q;
      tok_line_d   = tok_line_q;
      tok_col_d    = tok_col_q;
      pend_line_d  = pend_valid_q ? pend_line_q : line_q;
      pend_col_d   = pend_valid_q ? pend_col_q : col_q;
      cur_line     = pend_valid_q ? pend_line_q : line_q;
      cur_col      = pend_valid_q ? pend_col_q : col_q;
      if (have && !pend_valid_q) begin
         if (c == 8'h0A) begin line_d = line_q + 16'd1; col_d = 8'd1; end
         else col_d = col_q + 8'd1;
      end
      if (state_q == StIdle && have) begin start_line_d = cur_line; start_col_d = cur_col; end
      if (ld_open) begin tok_line_d = start_line_q; tok_col_d = start_col_q; end
      else if (ld_simple) begin tok_line_d = cur_line; tok_col_d = cur_col; end
      if (ld_simple && ld_kind == KEof) begin line_d = 16'd1; col_d = 8'd1; end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         acc_q        <= '0;
         frac_q       <= '0;
         err_q        <= 1'b0;
         name_q       <= '0;
         len_q        <= '0;
         open_q       <= 1'b0;
         open_kind_q  <= KEof;
         pend_valid_q <= 1'b0;
         pend_char_q  <= '0;
         pend_last_q  <= 1'b0;
         tok_full_q   <= 1'b0;
         tok_kind_q   <= KEof;
         tok_int_q    <= '0;
         tok_frac_q   <= '0;
         tok_name_q   <= '0;
         tok_len_q    <= '0;
         tok_err_q    <= 1'b0;
`ifdef LEXER_LINE_COL_EN
         line_q       <= 16'd1;
         col_q        <= 8'd1;
         pend_line_q  <= '0;
         pend_col_q   <= '0;
         start_line_q <= '0;
         start_col_q  <= '0;
         tok_line_q   <= '0;
         tok_col_q    <= '0;
`endif
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         frac_q       <= frac_d;
         err_q        <= err_d;
         name_q       <= name_d;
         len_q        <= len_d;
         open_q       <= open_d;
         open_kind_q  <= open_kind_d;
         pend_valid_q <= pend_valid_d;
         pend_char_q  <= pend_char_d;
         pend_last_q  <= pend_last_d;
         tok_full_q   <= tok_full_d;
         tok_kind_q   <= tok_kind_d;
         tok_int_q    <= tok_int_d;
         tok_frac_q   <= tok_frac_d;
         tok_name_q   <= tok_name_d;
         tok_len_q    <= tok_len_d;
         tok_err_q    <= tok_err_d;
`ifdef LEXER_LINE_COL_EN
         line_q       <= line_d;
         col_q        <= col_d;
         pend_line_q  <= pend_line_d;
         pend_col_q   <= pend_col_d;
         start_line_q <= start_line_d;
         start_col_q  <= start_col_d;
         tok_line_q   <= tok_line_d;
         tok_col_q    <= tok_col_d;
`endif
      end
   end

   assign tok_kind     = tok_kind_q;
   assign tok_int      = tok_int_q;
   assign tok_frac     = tok_frac_q;
   assign tok_name     = tok_name_q;
   assign tok_name_len = tok_len_q;
   assign tok_err      = tok_err_q;
`ifdef LEXER_LINE_COL_EN
   assign tok_line     = tok_line_q;
   assign tok_col      = tok_col_q;
`endif

endmodule
